// File: rtl/clkdiv_meter.sv
// -----------------------------------------------------------------------------
// clkdiv_meter
//
// Measures the period and high time of an asynchronous divided-clock signal,
// counted in cycles of clk. One measurement runs per start request. The result
// is offered with a valid/ready handshake and then held until the next capture.
//
// Measurement sequence:
//   IDLE --start--> ARM --rise--> MEAS --rise or saturation--> HOLD
//   HOLD --meas_valid & meas_ready--> IDLE
//
// Parameters:
//   CNT_W        width of the period/high-time counters and results
//   SYNC_STAGES  synchronizer depth on sig_in (2..4)
//
// Ports:
//   clk         single clock for all logic
//   rst         synchronous, active-high reset
//   sig_in      asynchronous signal under measurement
//   start       one-cycle request to begin a measurement (honoured in IDLE only)
//   meas_ready  consumer accepts the result while meas_valid is high
//   busy        high while a measurement is armed or running (ARM, MEAS)
//   meas_valid  result available (HOLD)
//   period      measured period, in clk cycles
//   high_time   measured high time, in clk cycles
//   overflow    period counter saturated; period is not a real measurement
// -----------------------------------------------------------------------------
module clkdiv_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             meas_ready,
  output logic             busy,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             overflow
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("clkdiv_meter: SYNC_STAGES must be in 2..4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Input synchronizer, delay flop and rise detector
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q,     sync_d;
  logic                   sync_dly_q, sync_dly_d;
  logic                   rise_q,     rise_d;

  // sync_q[0] is the first (possibly metastable) stage; the synchronized level
  // is the last stage. The rise pulse is registered so the FSM sees it aligned
  // with sync_dly_q, which is then the level that belongs to the same cycle.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], sig_in};
    sync_dly_d = sync_q[SYNC_STAGES-1];
    rise_d     = sync_q[SYNC_STAGES-1] & ~sync_dly_q;
  end

  // ---------------------------------------------------------------------------
  // Measurement FSM and counters
  // ---------------------------------------------------------------------------
  state_t           state_q,      state_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q,   high_cnt_d;
  logic [CNT_W-1:0] period_q,     period_d;
  logic [CNT_W-1:0] high_time_q,  high_time_d;
  logic             overflow_q,   overflow_d;
  logic             busy_q,       busy_d;
  logic             meas_valid_q, meas_valid_d;

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch instead of simply holding the flop.
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    overflow_d   = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
        end
      end

      // Counters stay frozen while waiting for the first edge; there is no
      // timeout, so a stuck-low or stuck-high input parks the meter here.
      ARM: begin
        if (rise_q) begin
          state_d      = MEAS;
          period_cnt_d = CNT_ONE;
          high_cnt_d   = CNT_ONE;
        end
      end

      // A rise always wins over saturation, so a period of exactly CNT_MAX is
      // reported as a clean measurement rather than an overflow.
      MEAS: begin
        if (rise_q) begin
          state_d     = HOLD;
          period_d    = period_cnt_q;
          high_time_d = high_cnt_q;
          overflow_d  = 1'b0;
        end else if (period_cnt_q == CNT_MAX) begin
          state_d     = HOLD;
          period_d    = CNT_MAX;
          high_time_d = high_cnt_q;
          overflow_d  = 1'b1;
        end else begin
          // high_cnt never exceeds period_cnt, so neither counter can wrap.
          period_cnt_d = period_cnt_q + CNT_ONE;
          if (sync_dly_q) begin
            high_cnt_d = high_cnt_q + CNT_ONE;
          end
        end
      end

      HOLD: begin
        if (meas_valid_q && meas_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // exactly with the state register, without a cycle of lag.
    busy_d       = (state_d == ARM) || (state_d == MEAS);
    meas_valid_d = (state_d == HOLD);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      sync_dly_q   <= 1'b0;
      rise_q       <= 1'b0;
      state_q      <= IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      meas_valid_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      sync_dly_q   <= sync_dly_d;
      rise_q       <= rise_d;
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign busy       = busy_q;
  assign meas_valid = meas_valid_q;
  assign period     = period_q;
  assign high_time  = high_time_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_clkdiv_meter.sv
// -----------------------------------------------------------------------------
// tb_clkdiv_meter
//
// Two meters share one stimulus: u0 with default parameters (CNT_W=16, two
// synchronizer stages) and u4 with CNT_W=4 and three stages, so saturation is
// reachable in a short run. A behavioural model derives every expected output
// from the sampled history of sig_in: the meter reacts to the level sig_in had
// SYNC_STAGES+1 edges earlier, a period is the distance between two such rises
// and the high time is the number of high samples between them.
// -----------------------------------------------------------------------------
module tb_clkdiv_meter;

  localparam int HIST = 30000;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_MEAS = 2;
  localparam int M_HOLD = 3;

  logic clk = 1'b0;
  logic rst, sig_in, start, meas_ready;

  logic        busy0, mv0, ov0;
  logic [15:0] per0, hi0;
  logic        busy1, mv1, ov1;
  logic [3:0]  per1, hi1;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  clkdiv_meter u0 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .meas_ready(meas_ready),
    .busy(busy0), .meas_valid(mv0), .period(per0), .high_time(hi0), .overflow(ov0)
  );

  clkdiv_meter #(.CNT_W(4), .SYNC_STAGES(3)) u4 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .meas_ready(meas_ready),
    .busy(busy1), .meas_valid(mv1), .period(per1), .high_time(hi1), .overflow(ov1)
  );

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_in(input string name, input logic [31:0] act, input int lo, input int hi);
    n_checks++;
    if ($isunknown(act) || int'(act) < lo || int'(act) > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit samp_h [HIST];
  int cyc      = 0;
  int last_rst = -1;
  bit cmp_on   = 0;

  int stg     [2] = '{2, 3};
  int cnt_max [2] = '{65535, 15};
  int m_mode  [2];
  int m_t0    [2];
  int m_hsum  [2];
  bit exp_busy  [2];
  bit exp_valid [2];
  int exp_per   [2];
  int exp_high  [2];
  bit exp_ovf   [2];

  // Level of sig_in that the meter acts on at edge m: the sample taken
  // s+1 edges earlier, or 0 if a reset edge lies in between.
  function automatic bit eff(input int m, input int s);
    int k;
    k = m - s - 1;
    if (k < 0 || k <= last_rst) return 1'b0;
    return samp_h[k];
  endfunction

  task automatic model_step(input int i, input int m);
    bit e, rise;
    int per;
    if (rst) begin
      m_mode[i]  = M_IDLE;
      m_hsum[i]  = 0;
      exp_per[i] = 0;
      exp_high[i] = 0;
      exp_ovf[i] = 1'b0;
    end else begin
      e    = eff(m, stg[i]);
      rise = e && !eff(m - 1, stg[i]);
      case (m_mode[i])
        M_IDLE: if (start) m_mode[i] = M_ARM;
        M_ARM: if (rise) begin
          m_mode[i] = M_MEAS;
          m_t0[i]   = m;
          m_hsum[i] = 1;
        end
        M_MEAS: begin
          per = m - m_t0[i];
          if (rise || per == cnt_max[i]) begin
            m_mode[i]   = M_HOLD;
            exp_per[i]  = per;
            exp_high[i] = m_hsum[i];
            exp_ovf[i]  = !rise;
          end else begin
            m_hsum[i] += int'(e);
          end
        end
        default: if (meas_ready) m_mode[i] = M_IDLE;
      endcase
    end
    exp_busy[i]  = (m_mode[i] == M_ARM) || (m_mode[i] == M_MEAS);
    exp_valid[i] = (m_mode[i] == M_HOLD);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (cyc >= HIST) begin
        $display("FAIL history: run exceeded %0d cycles", HIST);
        $fatal(1, "history overflow");
      end
      samp_h[cyc] = sig_in;
      if (rst) last_rst = cyc;
      model_step(0, cyc);
      model_step(1, cyc);
      if (rst) cmp_on = 1'b1;
      cyc++;
    end
  end

  task automatic cmp_inst(input int i, input logic b, input logic v,
                          input logic [15:0] p, input logic [15:0] h, input logic o);
    check($sformatf("u%0d.busy", i),       32'(b), 32'(exp_busy[i]));
    check($sformatf("u%0d.meas_valid", i), 32'(v), 32'(exp_valid[i]));
    check($sformatf("u%0d.period", i),     32'(p), 32'(exp_per[i]));
    check($sformatf("u%0d.high_time", i),  32'(h), 32'(exp_high[i]));
    check($sformatf("u%0d.overflow", i),   32'(o), 32'(exp_ovf[i]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        cmp_inst(0, busy0, mv0, per0, hi0, ov0);
        cmp_inst(1, busy1, mv1, {12'd0, per1}, {12'd0, hi1}, ov1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // sig_in generator: clock-synchronous square wave, constant level, or a
  // free-running wave of 7.5 clk periods whose edges never meet a clk edge.
  // ---------------------------------------------------------------------------
  int wave_n = 7;
  int wave_h = 4;
  int ph     = 0;
  bit gen_const = 1'b0;
  bit const_val = 1'b0;
  bit gen_async = 1'b0;

  initial begin
    sig_in = 1'b0;
    forever begin
      if (gen_async) begin
        sig_in = ~sig_in;
        #75;
      end else begin
        @(posedge clk);
        #1;
        if (gen_const) begin
          sig_in = const_val;
        end else begin
          if (ph >= wave_n) ph = 0;
          sig_in = (ph < wave_h);
          ph     = (ph + 1 >= wave_n) ? 0 : ph + 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int i, input int limit, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      seen = (i == 0) ? mv0 : mv1;
    end
    if (!seen) check({name, ".timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int pulses;
    rst        = 1'b1;
    start      = 1'b0;
    meas_ready = 1'b0;
    tick(3);
    check("reset.busy0", 32'(busy0), 0);
    check("reset.valid0", 32'(mv0), 0);
    check("reset.period0", 32'(per0), 0);
    check("reset.high1", 32'(hi1), 0);
    check("reset.ovf1", 32'(ov1), 0);
    rst = 1'b0;

    // Period 7, high 4, consumer always ready: one-cycle result.
    wave_n = 7; wave_h = 4; meas_ready = 1'b1;
    tick(5);
    pulse_start();
    wait_valid(0, 200, "p7");
    check("p7.period", 32'(per0), 7);
    check("p7.high", 32'(hi0), 4);
    check("p7.ovf", 32'(ov0), 0);
    @(negedge clk);
    check("p7.one_cycle", 32'(mv0), 0);
    tick(30);

    // Period 12, high 6, consumer stalls for 20 cycles.
    wave_n = 12; wave_h = 6; meas_ready = 1'b0;
    tick(2);
    pulse_start();
    wait_valid(0, 200, "p12");
    repeat (20) begin
      check("p12.valid", 32'(mv0), 1);
      check("p12.busy", 32'(busy0), 0);
      check("p12.period", 32'(per0), 12);
      check("p12.high", 32'(hi0), 6);
      @(negedge clk);
    end
    meas_ready = 1'b1;
    @(negedge clk);
    check("p12.accept_valid", 32'(mv0), 0);
    check("p12.accept_busy", 32'(busy0), 0);
    check("p12.hold_period", 32'(per0), 12);
    tick(40);

    // Period exactly 15 on the 4-bit meter: rise wins over saturation.
    wave_n = 15; wave_h = 5;
    tick(2);
    pulse_start();
    wait_valid(1, 200, "p15");
    check("p15.period", 32'(per1), 15);
    check("p15.high", 32'(hi1), 5);
    check("p15.ovf", 32'(ov1), 0);
    tick(60);

    // Second start while busy is ignored.
    wave_n = 10; wave_h = 3;
    tick(2);
    pulse_start();
    tick(3);
    check("dbl.busy", 32'(busy0), 1);
    pulse_start();
    wait_valid(0, 200, "dbl");
    check("dbl.period", 32'(per0), 10);
    check("dbl.high", 32'(hi0), 3);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (mv0) pulses++;
    end
    check("dbl.single_result", 32'(pulses), 0);

    // One rise then sig_in held high: 4-bit meter saturates, u0 stays busy.
    gen_const = 1'b1; const_val = 1'b0;
    tick(10);
    pulse_start();
    tick(5);
    const_val = 1'b1;
    wait_valid(1, 200, "sat");
    check("sat.period", 32'(per1), 15);
    check("sat.high", 32'(hi1), 15);
    check("sat.ovf", 32'(ov1), 1);
    tick(20);
    check("sat.u0_busy", 32'(busy0), 1);

    // Reset while u0 is in MEAS aborts it; a fresh measurement follows.
    rst = 1'b1;
    tick(2);
    check("rst.busy0", 32'(busy0), 0);
    check("rst.valid0", 32'(mv0), 0);
    check("rst.period0", 32'(per0), 0);
    check("rst.high0", 32'(hi0), 0);
    check("rst.ovf1", 32'(ov1), 0);
    rst = 1'b0;
    gen_const = 1'b0; wave_n = 9; wave_h = 3;
    tick(3);
    pulse_start();
    wait_valid(0, 200, "p9");
    check("p9.period", 32'(per0), 9);
    check("p9.high", 32'(hi0), 3);
    check("p9.ovf", 32'(ov0), 0);
    tick(40);

    // Free-running input at 7.5 cycles, 50 measurements.
    gen_async = 1'b1;
    tick(4);
    for (int k = 0; k < 50; k++) begin
      pulse_start();
      wait_valid(0, 100, "async");
      check_in("async.period", 32'(per0), 7, 8);
      check_in("async.high", 32'(hi0), 3, 4);
      check("async.ovf", 32'(ov0), 0);
      tick(1);
    end
    gen_async = 1'b0;
    tick(40);

    // Random waves, random handshake, random start and reset.
    for (int c = 0; c < 4000; c++) begin
      if (c % 50 == 0) begin
        wave_n = $urandom_range(2, 20);
        wave_h = $urandom_range(1, wave_n - 1);
      end
      meas_ready = ($urandom_range(0, 2) != 0);
      start      = ($urandom_range(0, 7) == 0);
      rst        = ($urandom_range(0, 149) == 0);
      tick(1);
    end
    start = 1'b0; rst = 1'b0; meas_ready = 1'b1;
    tick(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
